tcm_dp_ram: RTL and testbench
=============================

# tcm_dp_ram

Parametrised dual-port tightly-coupled memory for the RV32I pipeline: port 0 serves data accesses with byte-lane writes, port 1 serves instruction fetches. It replaces the fixed 64 KiB behavioural memory with configurable width and depth. It adds an in-hardware byte-stream loader, so program images are written through a handshake port instead of testbench tasks. It also flags out-of-range accesses on either port.

## Interface
- DATA_W, 32, word width in bits; multiple of 8; BE_W = DATA_W/8.
- ADDR_W, 14, word-address width of both ports.
- DEPTH_WORDS, 16384, implemented words; must be ≤ 2**ADDR_W (need not be a power of two).
- LOAD_BASE, 0, first word address written by the loader.

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- addr0_i  in  ADDR_W  port 0 word address.
- data0_i  in  DATA_W  port 0 write data.
- wr0_i  in  BE_W  port 0 byte-lane write enables; bit k writes bits [8k+7:8k].
- data0_o  out  DATA_W  port 0 read data.
- err0_o  out  1  port 0 out-of-range pulse.
- addr1_i  in  ADDR_W  port 1 word address.
- data1_i  in  DATA_W  port 1 write data.
- wr1_i  in  BE_W  port 1 byte-lane write enables.
- data1_o  out  DATA_W  port 1 read data.
- err1_o  out  1  port 1 out-of-range pulse.
- ld_start_i  in  1  start-load pulse.
- ld_valid_i  in  1  loader byte valid.
- ld_data_i  in  8  loader byte.
- ld_last_i  in  1  qualifies the final byte of the image.
- ld_ready_o  out  1  loader accepts a byte.
- ld_done_o  out  1  load-complete pulse.
- ld_err_o  out  1  load overflow, sticky until next ld_start_i.
- busy_o  out  1  loader active; core ports frozen.

## Operation
- Memory array: DEPTH_WORDS × DATA_W. Contents are not cleared by reset.
- Core ports, each cycle when busy_o=0:
  - Read: synchronous, read-first. A write and a read to the same address on either port return the old word.
  - Simultaneous writes from both ports to the same address and same lane: port 0 wins, per lane.
- Out of range (addr ≥ DEPTH_WORDS): the write is suppressed, read data is 0, and errN_o=1 in the cycle the data appears.
- Loader FSM: IDLE → LOAD → DONE → IDLE.
  - IDLE: ld_start_i=1 loads ptr=LOAD_BASE and lane=0, clears ld_err_o, and goes to LOAD.
  - LOAD: ld_ready_o=1. Each accepted byte (ld_valid_i & ld_ready_o) goes into the assembly register at lane position (little-endian; lane 0 = bits [7:0]) and increments lane.
  - Commit: when lane wraps after byte BE_W, or on acceptance of ld_last_i, the assembled word is written to ptr with all lanes enabled. Unfilled lanes are written as 0. Then ptr increments and lane resets to 0.
  - ld_last_i accepted → DONE. DONE lasts one cycle with ld_done_o=1, then returns to IDLE.
  - Commit with ptr ≥ DEPTH_WORDS: the write is suppressed, ld_err_o=1, and the FSM goes directly to DONE.
  - ld_start_i outside IDLE is ignored.
- busy_o=1 in LOAD and DONE. While busy, core writes are ignored, data0_o/data1_o hold their last values, and err0_o/err1_o are 0.

## Timing
- Reset values: data0_o=0, data1_o=0, err0_o=0, err1_o=0, ld_ready_o=0, ld_done_o=0, ld_err_o=0, busy_o=0; FSM=IDLE, lane=0, ptr=LOAD_BASE.
- Read latency is 1 cycle: address at edge n gives data after edge n+1.
- Write takes effect at the edge where it is presented.
- ld_start_i at edge n gives busy_o=1 and ld_ready_o=1 after edge n.
- The commit write lands at the edge that accepts the final lane byte. The word is readable with its normal 1-cycle latency once busy_o falls.
- ld_done_o is high for exactly the one cycle after the ld_last_i byte is accepted. busy_o falls together with ld_done_o.
- Reset asserted mid-load aborts the load: the partial word is discarded and already-committed words remain.

## Test plan
- Port 0 writes 0xDEADBEEF to addr 5 with wr0_i=0xF, then writes wr0_i=0x2 with data 0x0000AA00 → port 1 read of addr 5 returns 0xDEADAAEF one cycle after the address.
- Same-cycle port 0 write of 0x11111111 and port 1 read of addr 9, where addr 9 held 0x22222222 → data1_o=0x22222222; the next read returns 0x11111111.
- DEPTH_WORDS=1000: read and write at addr 1000 → data0_o=0, err0_o pulses one cycle, and addr 1000 mod 2**ADDR_W is unchanged.
- Loader with LOAD_BASE=0x15: start, then bytes 13 00 00 00 93 05, with ld_last_i on the 6th byte → word 0x15=0x00000013 and word 0x16=0x00000593. ld_done_o pulses once and busy_o deasserts in the same cycle.
- Loader with LOAD_BASE=DEPTH_WORDS-1 and 8 bytes → first word written, ld_err_o=1 at the second commit, FSM returns to IDLE, and no other words are modified.
- Reset asserted after 2 of 4 bytes of a load → outputs return to their reset values, target word is unchanged, and a fresh ld_start_i load completes normally.

Source files
------------

// File: rtl/tcm_dp_ram.sv
// Dual-port tightly-coupled memory: port 0 for data, port 1 for fetch.
// Both core ports do synchronous, read-first reads and byte-lane writes.
// A byte-stream loader packs incoming bytes into words and writes them
// starting at LOAD_BASE. The core ports are frozen while the loader runs.
//
// Loader handshake: a byte is transferred on a rising edge where both
// ld_valid_i and ld_ready_o are high. ld_last_i and ld_data_i are only
// sampled in that cycle. The producer may hold ld_valid_i high across
// cycles. ld_ready_o depends only on loader state, never on ld_valid_i.
module tcm_dp_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 16384,
  parameter int LOAD_BASE   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [DATA_W-1:0]   data0_i,
  input  logic [DATA_W/8-1:0] wr0_i,
  output logic [DATA_W-1:0]   data0_o,
  output logic                err0_o,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   data1_i,
  input  logic [DATA_W/8-1:0] wr1_i,
  output logic [DATA_W-1:0]   data1_o,
  output logic                err1_o,
  input  logic                ld_start_i,
  input  logic                ld_valid_i,
  input  logic [7:0]          ld_data_i,
  input  logic                ld_last_i,
  output logic                ld_ready_o,
  output logic                ld_done_o,
  output logic                ld_err_o,
  output logic                busy_o,
  output logic [1:0]          ld_state_o
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   BASE_L    = (ADDR_W+1)'(LOAD_BASE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BE_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;      // one extra bit so DEPTH_WORDS is representable
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] asm_q, asm_d;      // unfilled lanes are kept at zero
  logic              ld_err_q, ld_err_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              err0_q, err0_d, err1_q, err1_d;

  logic              busy, accept, commit, ptr_ok, in0, in1;
  logic [DATA_W-1:0] commit_word;

  assign busy        = (state_q != ST_IDLE);
  assign accept      = ld_valid_i && (state_q == ST_LOAD);
  assign commit      = accept && ((lane_q == LAST_LANE) || ld_last_i);
  assign ptr_ok      = (ptr_q < DEPTH_L);
  assign commit_word = asm_q | (DATA_W'(ld_data_i) << {lane_q, 3'b000});
  assign in0         = ({1'b0, addr0_i} < DEPTH_L);
  assign in1         = ({1'b0, addr1_i} < DEPTH_L);

  // Memory array write: loader owns it while busy, otherwise per-lane core writes with port 0 priority.
  always_ff @(posedge clk_i) begin
    if (busy) begin
      if (commit && ptr_ok) begin
        mem[ptr_q[ADDR_W-1:0]] <= commit_word;
      end
    end else begin
      for (int k = 0; k < BE_W; k++) begin
        if (wr0_i[k] && in0) begin
          mem[addr0_i][8*k +: 8] <= data0_i[8*k +: 8];
        end else if (wr1_i[k] && in1) begin
          mem[addr1_i][8*k +: 8] <= data1_i[8*k +: 8];
        end
      end
    end
  end

  // Read-data next state: old word (read-first), zero with error when out of range, hold while busy.
  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    if (!busy) begin
      data0_d = in0 ? mem[addr0_i] : '0;
      data1_d = in1 ? mem[addr1_i] : '0;
      err0_d  = !in0;
      err1_d  = !in1;
    end
  end

  // Loader FSM next state: byte packing, word commit, overflow detection.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    ld_err_d = ld_err_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_start_i) begin
          ptr_d    = BASE_L;
          lane_d   = '0;
          asm_d    = '0;
          ld_err_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (commit) begin
            asm_d  = '0;
            lane_d = '0;
            ptr_d  = ptr_q + 1'b1;
            if (!ptr_ok) begin
              ld_err_d = 1'b1;
              state_d  = ST_DONE;
            end else if (ld_last_i) begin
              state_d = ST_DONE;
            end
          end else begin
            asm_d  = commit_word;
            lane_d = lane_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any load in progress and drops the partial word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= BASE_L;
      lane_q   <= '0;
      asm_q    <= '0;
      ld_err_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      ld_err_q <= ld_err_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign data0_o    = data0_q;
  assign data1_o    = data1_q;
  assign err0_o     = err0_q;
  assign err1_o     = err1_q;
  assign ld_ready_o = (state_q == ST_LOAD);
  assign ld_done_o  = (state_q == ST_DONE);
  assign ld_err_o   = ld_err_q;
  assign busy_o     = busy;
  assign ld_state_o = state_q;

endmodule

// File: tb/tb_tcm_dp_ram.sv
// Directed bench for tcm_dp_ram. Instance a loads at word 0x15 and
// instance b loads at the last word, which exercises loader overflow.
// Both instances have 1000 words behind a 10-bit address.
module tb_tcm_dp_ram;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  logic          clk, rst;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic [3:0]    wr0, wr1;
  logic          start_a, start_b, ld_valid, ld_last;
  logic [7:0]    ld_data;

  logic [DW-1:0] d0_a, d1_a, d0_b, d1_b;
  logic          e0_a, e1_a, e0_b, e1_b;
  logic          rdy_a, done_a, lerr_a, busy_a;
  logic          rdy_b, done_b, lerr_b, busy_b;
  logic [1:0]    st_a, st_b;

  int n_vec = 0;
  int n_err = 0;

  tcm_dp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LOAD_BASE(21)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .addr0_i(addr0), .data0_i(data0), .wr0_i(wr0), .data0_o(d0_a), .err0_o(e0_a),
    .addr1_i(addr1), .data1_i(data1), .wr1_i(wr1), .data1_o(d1_a), .err1_o(e1_a),
    .ld_start_i(start_a), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(rdy_a), .ld_done_o(done_a), .ld_err_o(lerr_a), .busy_o(busy_a),
    .ld_state_o(st_a)
  );

  tcm_dp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LOAD_BASE(DEPTH-1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .addr0_i(addr0), .data0_i(data0), .wr0_i(wr0), .data0_o(d0_b), .err0_o(e0_b),
    .addr1_i(addr1), .data1_i(data1), .wr1_i(wr1), .data1_o(d1_b), .err1_o(e1_b),
    .ld_start_i(start_b), .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last),
    .ld_ready_o(rdy_b), .ld_done_o(done_b), .ld_err_o(lerr_b), .busy_o(busy_b),
    .ld_state_o(st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic core_wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    addr0 = a; data0 = d; wr0 = be;
    step();
    wr0 = 4'h0;
  endtask

  task automatic rd1(input logic [AW-1:0] a);
    addr1 = a;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; wr0 = '0; wr1 = '0;
    start_a = 0; start_b = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    step(); step();

    // reset state
    check("rst_data0", d0_a, 32'h0);
    check("rst_data1", d1_a, 32'h0);
    check("rst_err0", {31'd0, e0_a}, 32'd0);
    check("rst_err1", {31'd0, e1_a}, 32'd0);
    check("rst_ready", {31'd0, rdy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_lderr", {31'd0, lerr_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_state", {30'd0, st_a}, 32'd0);
    rst = 1'b0;
    step();

    // byte-lane write then fetch-port read
    core_wr0(10'd5, 32'hDEADBEEF, 4'hF);
    core_wr0(10'd5, 32'h0000AA00, 4'h2);
    rd1(10'd5);
    check("lane_merge", d1_a, 32'hDEADAAEF);

    // read-first on both ports
    core_wr0(10'd9, 32'h22222222, 4'hF);
    addr1 = 10'd9;
    core_wr0(10'd9, 32'h11111111, 4'hF);
    check("rf_port1_old", d1_a, 32'h22222222);
    check("rf_port0_old", d0_a, 32'h22222222);
    step();
    check("rf_port1_new", d1_a, 32'h11111111);

    // simultaneous writes: port 0 wins lane 0, port 1 takes lane 1
    core_wr0(10'd3, 32'h12345678, 4'hF);
    addr0 = 10'd3; data0 = 32'hAAAAAAAA; wr0 = 4'h1;
    addr1 = 10'd3; data1 = 32'hBBBBBBBB; wr1 = 4'h3;
    step();
    wr0 = 4'h0; wr1 = 4'h0;
    step();
    check("collide", d1_a, 32'h1234BBAA);

    // out of range on both ports
    addr0 = 10'd1000; data0 = 32'hFFFFFFFF; wr0 = 4'hF; addr1 = 10'd1023;
    step();
    wr0 = 4'h0;
    check("oor_data0", d0_a, 32'h0);
    check("oor_err0", {31'd0, e0_a}, 32'd1);
    check("oor_data1", d1_a, 32'h0);
    check("oor_err1", {31'd0, e1_a}, 32'd1);
    addr0 = 10'd5; addr1 = 10'd3;
    step();
    check("oor_err0_clr", {31'd0, e0_a}, 32'd0);
    check("oor_after_d0", d0_a, 32'hDEADAAEF);
    check("oor_no_alias", d1_a, 32'h1234BBAA);

    // loader on instance a: 6 bytes, last word partially filled
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("ld_busy", {31'd0, busy_a}, 32'd1);
    check("ld_ready", {31'd0, rdy_a}, 32'd1);
    check("ld_state", {30'd0, st_a}, 32'd1);
    // core write while busy must be ignored and outputs must hold
    core_wr0(10'd9, 32'h77777777, 4'hF);
    check("frz_data0", d0_a, 32'hDEADAAEF);
    check("frz_err0", {31'd0, e0_a}, 32'd0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    start_a = 1'b1;                 // ignored outside IDLE
    step();
    start_a = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("ld_mid_busy", {31'd0, busy_a}, 32'd1);
    send_byte(8'h93, 1'b0);
    send_byte(8'h05, 1'b1);
    check("ld_done_hi", {31'd0, done_a}, 32'd1);
    check("ld_done_busy", {31'd0, busy_a}, 32'd1);
    step();
    check("ld_done_lo", {31'd0, done_a}, 32'd0);
    check("ld_busy_lo", {31'd0, busy_a}, 32'd0);
    check("ld_lderr_a", {31'd0, lerr_a}, 32'd0);
    rd1(10'h15);
    check("ld_word15", d1_a, 32'h00000013);
    rd1(10'h16);
    check("ld_word16", d1_a, 32'h00000593);
    rd1(10'd9);
    check("frz_no_write", d1_a, 32'h11111111);

    // loader overflow on instance b
    core_wr0(10'd998, 32'hCAFEF00D, 4'hF);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), i == 8);
      if (i == 4) check("ovf_no_err_yet", {31'd0, lerr_b}, 32'd0);
    end
    check("ovf_err", {31'd0, lerr_b}, 32'd1);
    check("ovf_done", {31'd0, done_b}, 32'd1);
    step();
    check("ovf_idle", {30'd0, st_b}, 32'd0);
    check("ovf_busy_lo", {31'd0, busy_b}, 32'd0);
    check("ovf_sticky", {31'd0, lerr_b}, 32'd1);
    rd1(10'd999);
    check("ovf_word999", d1_b, 32'h04030201);
    rd1(10'd998);
    check("ovf_word998", d1_b, 32'hCAFEF00D);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("ovf_err_clr", {31'd0, lerr_b}, 32'd0);
    send_byte(8'hEE, 1'b1);
    step();
    rd1(10'd999);
    check("ovf_reload", d1_b, 32'h000000EE);

    // reset mid-load on instance a
    core_wr0(10'd21, 32'h55667788, 4'hF);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    rst = 1'b1;
    #2;
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_ready", {31'd0, rdy_a}, 32'd0);
    check("abort_state", {30'd0, st_a}, 32'd0);
    check("abort_data1", d1_a, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    rd1(10'd21);
    check("abort_word", d1_a, 32'h55667788);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b1);
    check("fresh_done", {31'd0, done_a}, 32'd1);
    step();
    rd1(10'd21);
    check("fresh_word", d1_a, 32'hD4C3B2A1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
